// File: rtl/mawg_out_stage_if.sv
// Sample bus between mawg and its output stage: the incoming sample strobe/data
// and the registered DAC-side outputs.
interface mawg_out_stage_if #(
    parameter int unsigned WAVE_WIDTH = 16
);
    logic                  wave_valid;
    logic [WAVE_WIDTH-1:0] wave_out;
    logic [WAVE_WIDTH-1:0] dac_data;
    logic                  dac_strobe;

    modport master (
        output wave_valid,
        output wave_out,
        input  dac_data,
        input  dac_strobe
    );

    modport slave (
        input  wave_valid,
        input  wave_out,
        output dac_data,
        output dac_strobe
    );
endinterface

// File: rtl/mawg_out_stage.sv
// Elastic FIFO plus rate-divided replay of mawg samples to a DAC, with sticky under/overflow flags.
// Optional gain/offset scaling stage enabled by defining MAWG_OUT_SCALE_EN.
module mawg_out_stage #(
    parameter int unsigned WAVE_WIDTH      = 16,
    parameter int unsigned FIFO_DEPTH_LOG2 = 4,
    parameter int unsigned PREFILL         = 4,
    parameter int unsigned DIV_WIDTH       = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    mawg_out_stage_if.slave          bus,
    input  logic                     enable,
    input  logic [DIV_WIDTH-1:0]     rate_div,
    input  logic                     clear_flags,
    input  logic [15:0]              gain,
    input  logic [WAVE_WIDTH-1:0]    offset,
    output logic [FIFO_DEPTH_LOG2:0] fifo_level,
    output logic                     running,
    output logic                     underrun,
    output logic                     overflow
);
    localparam int unsigned Depth = 2 ** FIFO_DEPTH_LOG2;
    localparam int unsigned PtrW  = FIFO_DEPTH_LOG2;
    localparam int unsigned LvlW  = FIFO_DEPTH_LOG2 + 1;

    typedef enum logic [1:0] {StIdle, StPrefill, StRun} state_e;
    state_e state_q, state_d;

    logic [WAVE_WIDTH-1:0] mem_q [Depth];
    logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [LvlW-1:0]       level_q, level_d;
    logic [DIV_WIDTH-1:0]  cnt_q, cnt_d;
    logic [WAVE_WIDTH-1:0] dac_data_q, dac_data_d;
    logic                  dac_strobe_q, dac_strobe_d;
    logic                  underrun_q, overflow_q;
    logic [WAVE_WIDTH-1:0] head;

    logic flush, tick, fifo_full, fifo_empty, pop, push, ovf_set, urun_set;

    // FSM: state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= StIdle;
        else       state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (enable) state_d = StPrefill;
            StPrefill: begin
                if (!enable)                          state_d = StIdle;
                else if (level_q >= LvlW'(PREFILL))   state_d = StRun;
            end
            StRun:     if (!enable) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // FSM: outputs. A tick is suppressed in the flush cycle since the FIFO is being emptied.
    always_comb begin
        running = (state_q == StRun);
        flush   = (state_q != StIdle) && !enable;
        tick    = running && enable && (cnt_q == '0);
    end

    always_comb begin
        fifo_full  = (level_q == LvlW'(Depth));
        fifo_empty = (level_q == '0);
        pop        = tick && !fifo_empty;
        push       = bus.wave_valid && !flush && (!fifo_full || pop);
        ovf_set    = bus.wave_valid && !flush && fifo_full && !pop;
        urun_set   = tick && fifo_empty;
        level_d    = flush ? '0 : level_q + LvlW'(push) - LvlW'(pop);
        cnt_d      = '0;
        if (running && enable) cnt_d = (cnt_q >= rate_div) ? '0 : cnt_q + DIV_WIDTH'(1);
    end

    assign head = mem_q[rd_ptr_q];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            cnt_q      <= '0;
            underrun_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            level_q    <= level_d;
            cnt_q      <= cnt_d;
            underrun_q <= urun_set | (underrun_q & ~clear_flags);
            overflow_q <= ovf_set  | (overflow_q & ~clear_flags);
            if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= bus.wave_out;
    end

`ifdef MAWG_OUT_SCALE_EN
    localparam int unsigned ProdW = WAVE_WIDTH + 16;
    localparam int unsigned SumW  = ProdW + 1;

    logic                   s1_valid_q, s1_pop_q;
    logic [WAVE_WIDTH-1:0]  s1_sample_q;
    logic signed [ProdW-1:0] prod;
    logic signed [SumW-1:0]  sum;
    logic [WAVE_WIDTH-1:0]  scaled;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s1_pop_q    <= 1'b0;
            s1_sample_q <= '0;
        end else if (flush) begin
            s1_valid_q <= 1'b0;
            s1_pop_q   <= 1'b0;
        end else begin
            s1_valid_q <= tick;
            s1_pop_q   <= pop;
            if (pop) s1_sample_q <= head;
        end
    end

    // Full-precision product, floor shift, then saturate to the signed sample range.
    always_comb begin
        prod = $signed(s1_sample_q) * $signed(gain);
        sum  = SumW'(prod >>> 14) + SumW'($signed(offset));
        if ((&sum[SumW-1:WAVE_WIDTH-1]) || !(|sum[SumW-1:WAVE_WIDTH-1])) begin
            scaled = sum[WAVE_WIDTH-1:0];
        end else if (sum[SumW-1]) begin
            scaled = {1'b1, {(WAVE_WIDTH-1){1'b0}}};
        end else begin
            scaled = {1'b0, {(WAVE_WIDTH-1){1'b1}}};
        end
    end

    always_comb begin
        dac_data_d   = dac_data_q;
        dac_strobe_d = 1'b0;
        if (flush) begin
            dac_data_d = '0;
        end else if (s1_valid_q) begin
            dac_strobe_d = 1'b1;
            if (s1_pop_q) dac_data_d = scaled;
        end
    end
`else
    logic unused_scale;
    assign unused_scale = ^{gain, offset};

    always_comb begin
        dac_data_d   = dac_data_q;
        dac_strobe_d = 1'b0;
        if (flush) begin
            dac_data_d = '0;
        end else if (tick) begin
            dac_strobe_d = 1'b1;
            if (pop) dac_data_d = head;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dac_data_q   <= '0;
            dac_strobe_q <= 1'b0;
        end else begin
            dac_data_q   <= dac_data_d;
            dac_strobe_q <= dac_strobe_d;
        end
    end

    assign bus.dac_data   = dac_data_q;
    assign bus.dac_strobe = dac_strobe_q;
    assign fifo_level     = level_q;
    assign underrun       = underrun_q;
    assign overflow       = overflow_q;
endmodule

// File: tb/tb_mawg_out_stage.sv
// Randomized bench for mawg_out_stage against a queue-based reference model.
// Covers the MAWG_OUT_SCALE_EN build when that macro is defined.
module tb_mawg_out_stage;
    localparam int unsigned WW    = 16;
    localparam int unsigned FL    = 4;
    localparam int unsigned PF    = 4;
    localparam int unsigned DW    = 16;
    localparam int          DEPTH = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic [DW-1:0] rate_div = '0;
    logic          clear_flags = 1'b0;
    logic [15:0]   gain = 16'h4000;
    logic [WW-1:0] offset = '0;
    logic [FL:0]   fifo_level;
    logic          running, underrun, overflow;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mawg_out_stage_if #(.WAVE_WIDTH(WW)) bus ();

    mawg_out_stage #(
        .WAVE_WIDTH     (WW),
        .FIFO_DEPTH_LOG2(FL),
        .PREFILL        (PF),
        .DIV_WIDTH      (DW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .enable     (enable),
        .rate_div   (rate_div),
        .clear_flags(clear_flags),
        .gain       (gain),
        .offset     (offset),
        .fifo_level (fifo_level),
        .running    (running),
        .underrun   (underrun),
        .overflow   (overflow)
    );

    // Reference model: phase 0 idle, 1 prefill, 2 run; q holds queued samples.
    int          phase = 0;
    int          run_cnt = 0;
    logic [15:0] q[$];
    logic [15:0] exp_data = '0;
    bit          exp_strobe = 0, exp_urun = 0, exp_ovf = 0, exp_running = 0;
    int          exp_level = 0;
    bit          pend_valid = 0, pend_has = 0;
    logic [15:0] pend_val = '0;

    function automatic logic [15:0] scale(input logic [15:0] s);
        longint p = longint'($signed(s)) * longint'($signed(gain));
        longint y = (p >>> 14) + longint'($signed(offset));
        if (y > 32767)  y = 32767;
        if (y < -32768) y = -32768;
        return y[15:0];
    endfunction

    function automatic void model_reset();
        q.delete();
        phase = 0; run_cnt = 0;
        exp_data = '0; exp_strobe = 0; exp_urun = 0; exp_ovf = 0;
        exp_running = 0; exp_level = 0;
        pend_valid = 0; pend_has = 0; pend_val = '0;
    endfunction

    function automatic void model_step();
        int          lvl0 = q.size();
        bit          leaving = (phase != 0) && !enable;
        bit          tick = 0, ev_valid = 0, ev_has = 0, u_set = 0, o_set = 0;
        logic [15:0] ev_val = '0;
        exp_strobe = 0;
        if (phase == 2 && enable) begin
            tick = (run_cnt % (int'(rate_div) + 1)) == 0;
            run_cnt++;
        end
        if (tick) begin
            ev_valid = 1;
            if (q.size() > 0) begin ev_has = 1; ev_val = q.pop_front(); end
            else u_set = 1;
        end
        if (bus.wave_valid && !leaving) begin
            if (q.size() < DEPTH) q.push_back(bus.wave_out);
            else o_set = 1;
        end
        if (leaving) begin
            q.delete();
            exp_data = '0; run_cnt = 0; pend_valid = 0;
        end else begin
`ifdef MAWG_OUT_SCALE_EN
            if (pend_valid) begin
                exp_strobe = 1;
                if (pend_has) exp_data = scale(pend_val);
            end
            pend_valid = ev_valid; pend_has = ev_has; pend_val = ev_val;
`else
            if (ev_valid) begin
                exp_strobe = 1;
                if (ev_has) exp_data = ev_val;
            end
`endif
        end
        exp_urun = u_set || (exp_urun && !clear_flags);
        exp_ovf  = o_set || (exp_ovf && !clear_flags);
        case (phase)
            0: if (enable) phase = 1;
            1: if (!enable) phase = 0; else if (lvl0 >= PF) phase = 2;
            default: if (!enable) phase = 0;
        endcase
        exp_level   = q.size();
        exp_running = (phase == 2);
    endfunction

    always @(posedge clk) begin
        if (reset) model_reset();
        else       model_step();
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic check_all();
        check_eq("dac_data",   32'(bus.dac_data),   32'(exp_data));
        check_eq("dac_strobe", 32'(bus.dac_strobe), 32'(exp_strobe));
        check_eq("fifo_level", 32'(fifo_level),     32'(exp_level));
        check_eq("running",    32'(running),        32'(exp_running));
        check_eq("underrun",   32'(underrun),       32'(exp_urun));
        check_eq("overflow",   32'(overflow),       32'(exp_ovf));
    endtask

    // Called at a negedge: drive inputs, let one posedge pass, check at the next negedge.
    task automatic step(input bit wv, input logic [15:0] d, input bit en, input bit cf);
        bus.wave_valid = wv; bus.wave_out = d; enable = en; clear_flags = cf;
        @(negedge clk);
        check_all();
    endtask

    task automatic do_reset();
        bus.wave_valid = 1'b0; enable = 1'b0; clear_flags = 1'b0;
        reset = 1'b1;
        #1;
        check_eq("rst_dac_data",   32'(bus.dac_data),   32'h0);
        check_eq("rst_dac_strobe", 32'(bus.dac_strobe), 32'h0);
        check_eq("rst_fifo_level", 32'(fifo_level),     32'h0);
        check_eq("rst_running",    32'(running),        32'h0);
        check_eq("rst_underrun",   32'(underrun),       32'h0);
        check_eq("rst_overflow",   32'(overflow),       32'h0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        step(0, '0, 0, 0);
    endtask

`ifdef MAWG_OUT_SCALE_EN
    task automatic scale_case(input logic [15:0] s, input logic [15:0] g, input logic [15:0] o,
                              input logic [15:0] want);
        bit found = 0;
        gain = g; offset = o; rate_div = 3;
        do_reset();
        step(1, s, 0, 0);
        for (int i = 0; i < 10 && !found; i++) begin
            step(0, '0, 1, 0);
            if (bus.dac_strobe) begin
                found = 1;
                check_eq("scale_value", 32'(bus.dac_data), 32'(want));
            end
        end
        check_eq("scale_strobe_seen", 32'(found), 32'h1);
    endtask
`endif

    logic [15:0] plan_samples [4];

    initial begin
        bit en_r = 0;
        int dens = 50;
        bus.wave_valid = 1'b0; bus.wave_out = '0;
        plan_samples[0] = 16'h010f; plan_samples[1] = 16'h011f;
        plan_samples[2] = 16'h020f; plan_samples[3] = 16'h021f;
        @(negedge clk);
        do_reset();

        // Prefill then play at one sample per 4 cycles, then starve.
        rate_div = 3;
        for (int i = 0; i < 4; i++) step(1, plan_samples[i], 0, 0);
        repeat (20) step(0, '0, 1, 0);
        check_eq("plan_underrun_set", 32'(underrun), 32'h1);
        check_eq("plan_hold_last",    32'(bus.dac_data), 32'h021f);
        step(0, '0, 1, 1);
        check_eq("plan_underrun_clr", 32'(underrun), 32'h0);

        // Flush, then overfill while idle.
        step(0, '0, 0, 0);
        for (int i = 0; i < 17; i++) step(1, 16'(16'h0a00 + i), 0, 0);
        check_eq("plan_level_full", 32'(fifo_level), 32'd16);
        check_eq("plan_overflow",   32'(overflow),   32'h1);
        step(0, '0, 0, 1);

        // Full FIFO, tick every cycle, one push per cycle: level stays full.
        rate_div = 0;
        step(0, '0, 1, 0);
        step(0, '0, 1, 0);
        repeat (30) step(1, 16'($urandom), 1, 0);
        check_eq("burst_level",    32'(fifo_level), 32'd16);
        check_eq("burst_overflow", 32'(overflow),   32'h0);

        // Stop mid-run with 5 queued.
        step(0, '0, 0, 0);
        rate_div = 40;
        for (int i = 0; i < 6; i++) step(1, 16'(16'h0b00 + i), 0, 0);
        repeat (3) step(0, '0, 1, 0);
        check_eq("stop_level_before", 32'(fifo_level), 32'd5);
        step(0, '0, 0, 0);
        check_eq("stop_level",   32'(fifo_level),   32'h0);
        check_eq("stop_dac",     32'(bus.dac_data), 32'h0);
        check_eq("stop_running", 32'(running),      32'h0);

        // Reset mid-run.
        for (int i = 0; i < 5; i++) step(1, 16'(16'h0c00 + i), 0, 0);
        repeat (4) step(0, '0, 1, 0);
        do_reset();

`ifdef MAWG_OUT_SCALE_EN
        scale_case(16'h0100, 16'h2000, 16'h0010, 16'h0090);
        scale_case(16'h7000, 16'h7fff, 16'h0000, 16'h7fff);
        scale_case(16'h8000, 16'h4000, 16'hffff, 16'h8000);
        do_reset();
`endif

        // Randomized sessions; rate/gain/offset change only while not playing.
        for (int i = 0; i < 3000; i++) begin
            if (phase != 2 && $urandom_range(0, 3) == 0) begin
                rate_div = DW'($urandom_range(0, 5));
                dens     = int'($urandom_range(10, 90));
            end
`ifdef MAWG_OUT_SCALE_EN
            if (phase == 0 && $urandom_range(0, 3) == 0) begin
                gain   = 16'($urandom);
                offset = 16'($urandom);
            end
`endif
            if ($urandom_range(0, 60) == 0) en_r = !en_r;
            step(int'($urandom_range(0, 99)) < dens, 16'($urandom), en_r,
                 $urandom_range(0, 15) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mawg_out_stage.md
Name: mawg_out_stage

Overview:
- Output stage directly downstream of mawg: absorbs bursty wave_valid/wave_out samples into an elastic FIFO.
- Replays the samples to a DAC at a fixed programmable sample rate, one sample per rate tick.
- Flags underrun and overflow; holds the last value on starvation.

Parameters:
- WAVE_WIDTH, 16, sample width; matches mawg WAVE_WIDTH.
- FIFO_DEPTH_LOG2, 4, FIFO holds 2**FIFO_DEPTH_LOG2 samples.
- PREFILL, 4, samples required in the FIFO before playback starts; 1..2**FIFO_DEPTH_LOG2.
- DIV_WIDTH, 16, width of rate_div.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- wave_valid  in  1  sample strobe from mawg.
- wave_out  in  WAVE_WIDTH  sample from mawg; two's complement.
- enable  in  1  level; high = play, low = stop and flush.
- rate_div  in  DIV_WIDTH  tick period minus 1, in clk cycles.
- clear_flags  in  1  pulse; clears underrun and overflow.
- gain  in  16  signed Q2.14 (0x4000 = 1.0); used only with the macro.
- offset  in  WAVE_WIDTH  signed; used only with the macro.
- dac_data  out  WAVE_WIDTH  registered DAC sample.
- dac_strobe  out  1  one-cycle pulse when dac_data is updated.
- fifo_level  out  FIFO_DEPTH_LOG2+1  current occupancy.
- running  out  1  high in RUN.
- underrun  out  1  sticky.
- overflow  out  1  sticky.

Behaviour:
- Reset (asynchronous): all outputs 0, FIFO empty, state IDLE, divider counter 0.
- State IDLE:
  - FIFO accepts writes.
  - enable=1 -> PREFILL.
- State PREFILL:
  - fifo_level >= PREFILL -> RUN.
  - enable=0 -> IDLE.
- State RUN:
  - running=1.
  - enable=0 -> IDLE.
- Leaving PREFILL or RUN for IDLE:
  - FIFO flushed in that cycle; a write in the same cycle is discarded.
  - dac_data <= 0 next cycle; no strobe.
- Divider:
  - Counter is held at 0 outside RUN.
  - In RUN, tick when counter==0; counter then counts 1..rate_div and wraps to 0.
  - Tick period is rate_div+1 cycles; rate_div=0 gives a tick every cycle.
  - First tick falls on the first RUN cycle.
  - rate_div is sampled live.
- Tick with FIFO non-empty: pop the head sample.
  - Without the macro: dac_data = sample and dac_strobe=1 in cycle T+1, where T is the tick cycle.
- Tick with FIFO empty:
  - underrun <= 1.
  - dac_data holds its last value; dac_strobe still pulses at T+1.
  - State stays RUN; no return to PREFILL.
- FIFO write: wave_valid=1 pushes wave_out.
  - Full with no pop in the same cycle: sample dropped, overflow <= 1.
  - Full with a pop in the same cycle: write accepted, level unchanged.
- Simultaneous push and pop when empty: pop sees empty (underrun); push is stored.
- fifo_level is registered and reflects pushes and pops one cycle later.
- clear_flags clears both sticky flags; a set event in the same cycle wins.
- FIFO pointers are FIFO_DEPTH_LOG2 bits wide and wrap modulo depth.
- Full and empty are derived from the level counter.

Optional Feature:
- Macro: MAWG_OUT_SCALE_EN.
- When defined:
  - Adds one pipeline stage computing y = ((sample * gain) >>> 14) + offset.
  - Full-precision signed arithmetic, arithmetic shift (floor), saturation to the WAVE_WIDTH signed range.
  - dac_data and dac_strobe appear at T+2.
  - Underrun repeats the last scaled value.
  - The flush clears the pipeline.
- When undefined:
  - gain and offset are ignored.
  - Output appears at T+1.

Test Plan:
- PREFILL=4, rate_div=3: push 0x010f, 0x011f, 0x020f, 0x021f, then enable=1 -> RUN after the 4th sample is stored; dac_data takes 010f, 011f, 020f, 021f with strobes exactly 4 cycles apart; no flags.
- Continue running with no further pushes -> next tick sets underrun=1, dac_data holds 021f, strobe still pulses; clear_flags -> underrun=0.
- enable=0, push 17 samples back-to-back with FIFO_DEPTH_LOG2=4 -> fifo_level=16, overflow=1, 17th sample absent on later playback.
- rate_div=0, FIFO full, mawg bursting one sample per cycle in RUN -> simultaneous push/pop, level constant at 16, no overflow, strobe every cycle.
- Mid-RUN enable=0 with 5 samples queued -> next cycle fifo_level=0, dac_data=0, running=0; assert reset mid-RUN -> all outputs 0 immediately.
- With MAWG_OUT_SCALE_EN:
  - gain=0x2000, offset=0x0010, sample 0x0100 -> 0x0090 at T+2.
  - gain=0x7fff, sample 0x7000 -> saturates to 0x7fff.
  - gain=0x4000, sample 0x8000, offset=0xffff -> 0x8000 (saturated).
